// File: rtl/sram_responder_pkg.sv
// Shared types and defaults for the MEM-stage SRAM responder.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    localparam int unsigned DATA_BASE_DEF   = 1024;
    localparam int unsigned SRAM_AW_DEF     = 18;
    localparam int unsigned WAIT_CYCLES_DEF = 5;

    function automatic logic is_busy(input state_t s);
        return (s == LOW) || (s == HIGH);
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable 0..MAX wait-state counter; tc flags the last cycle of a half-word access.
module sram_wait_counter #(
    parameter int unsigned MAX = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int unsigned CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == CW'(MAX));

endmodule

// File: rtl/sram_responder.sv
// Performs one 32-bit MEM-stage access as two 16-bit SRAM half-word accesses with wait states.
// Optional SRAM_RANGE_CHECK_EN adds an err output and rejects out-of-window addresses.
module sram_responder
    import sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int unsigned DATA_BASE   = DATA_BASE_DEF,
    parameter int unsigned SRAM_AW     = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n
`ifdef SRAM_RANGE_CHECK_EN
    ,
    output logic               err
`endif
);

    state_t             state;
    logic               wr_q;
    logic [SRAM_AW-2:0] idx_q;
    logic [31:0]        wdata_q;
    logic [31:0]        in_off;
    logic               req;
    logic               busy;
    logic               half;
    logic               tc;
    logic               unused_bits;

    assign req    = rd_en | wr_en;
    assign busy   = is_busy(state);
    assign half   = (state == HIGH) ? HALF_HI : HALF_LO;
    assign in_off = address - DATA_BASE;
    // Byte lane bits never reach the SRAM; upper offset bits wrap unless range-checked.
    assign unused_bits = ^{in_off[1:0], in_off[31:SRAM_AW+1]};

`ifdef SRAM_RANGE_CHECK_EN
    logic oob;
    assign oob = (address < DATA_BASE) || ((in_off >> (SRAM_AW + 1)) != 32'd0);
`endif

    sram_wait_counter #(
        .MAX (WAIT_CYCLES)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .load (~busy | tc),
        .en   (busy),
        .tc   (tc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        wr_q    <= wr_en;
                        idx_q   <= in_off[SRAM_AW:2];
                        wdata_q <= wdata;
`ifdef SRAM_RANGE_CHECK_EN
                        if (oob) begin
                            state <= DONE;
                            rdata <= '0;
                        end else begin
                            state <= LOW;
                        end
`else
                        state <= LOW;
`endif
                    end
                end
                LOW: begin
                    if (tc) begin
                        if (!wr_q) rdata[15:0] <= sram_dq_in;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (tc) begin
                        if (!wr_q) rdata[31:16] <= sram_dq_in;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SRAM_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else begin
            err <= (state == IDLE) && req && oob;
        end
    end
`endif

    // A fresh request drops ready in the same cycle so the pipeline freezes immediately.
    assign ready       = (!rst || state == IDLE) ? ~req : (state == DONE);
    assign sram_addr   = busy ? {idx_q, half} : '0;
    assign sram_dq_oe  = busy & wr_q;
    assign sram_we_n   = ~(busy & wr_q);
    assign sram_oe_n   = ~(busy & ~wr_q);
    assign sram_dq_out = (busy & wr_q) ? (half ? wdata_q[31:16] : wdata_q[15:0]) : 16'h0000;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder with a behavioural asynchronous SRAM model.
module tb_sram_responder;

    localparam int W  = 5;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en;
    logic          wr_en;
    logic [31:0]   address;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic [15:0]   sram_dq_in;
    logic          sram_dq_oe;
    logic          sram_we_n;
    logic          sram_oe_n;
`ifdef SRAM_RANGE_CHECK_EN
    logic          err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bit   [15:0] mem [0:(1<<AW)-1];
    logic [31:0] exp_q [$];
    logic [31:0] last_rdata;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [AW-1:0] lo;
        logic [31:0]   exp_rd;
        logic          oob;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    sram_responder #(
        .WAIT_CYCLES (W),
        .DATA_BASE   (1024),
        .SRAM_AW     (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n)
`ifdef SRAM_RANGE_CHECK_EN
        ,
        .err         (err)
`endif
    );

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
    end
    assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_rdata(input string name);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, actual %h", name, rdata);
        end else begin
            check(name, rdata, exp_q.pop_front());
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
        check({tag, "_oe_n"}, 32'(sram_oe_n), 32'd1);
        check({tag, "_dq_oe"}, 32'(sram_dq_oe), 32'd0);
        check({tag, "_addr"}, 32'(sram_addr), 32'd0);
    endtask

    // Called one step after a rising edge; returns one step after the edge that leaves DONE.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [AW-1:0] lo,
                           input logic [31:0] exp_rd);
        logic [AW-1:0] ea;
        logic [15:0]   ed;
        rd_en   = rd;
        wr_en   = wr;
        address = a;
        wdata   = d;
        exp_q.push_back(wr ? last_rdata : exp_rd);
        if (!wr) last_rdata = exp_rd;
        @(negedge clk);
        check("ready_req", 32'(ready), 32'd0);
        for (int c = 1; c <= 2*W+2; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                rd_en   = 1'b0;
                wr_en   = 1'b0;
                address = 32'hFFFF_FFF0;
                wdata   = 32'h5555_AAAA;
            end
            @(negedge clk);
            ea = (c <= W+1) ? lo : (lo | AW'(1));
            ed = (c <= W+1) ? d[15:0] : d[31:16];
            check($sformatf("ready_c%0d", c), 32'(ready), 32'd0);
            check($sformatf("addr_c%0d", c), 32'(sram_addr), 32'(ea));
            check($sformatf("we_n_c%0d", c), 32'(sram_we_n), 32'(!wr));
            check($sformatf("oe_n_c%0d", c), 32'(sram_oe_n), 32'(wr));
            check($sformatf("dq_oe_c%0d", c), 32'(sram_dq_oe), 32'(wr));
            if (wr) check($sformatf("dq_out_c%0d", c), 32'(sram_dq_out), 32'(ed));
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ready_done", 32'(ready), 32'd1);
        check_quiet("done");
        check_rdata("rdata_done");
`ifdef SRAM_RANGE_CHECK_EN
        check("err_done", 32'(err), 32'd0);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 32'd1028,     32'hDEAD_BEEF, 18'd2,       32'h0,         1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'd1028,     32'h0,         18'd2,       32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 32'd1032,     32'h1234_5678, 18'd4,       32'h0,         1'b0};
        tbl[3]  = '{1'b1, 1'b1, 32'd1036,     32'hCAFE_F00D, 18'd6,       32'h0,         1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'd1035,     32'h0,         18'd4,       32'h1234_5678, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 32'd1036,     32'h0,         18'd6,       32'hCAFE_F00D, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 32'd1040,     32'h0,         18'd8,       32'h0,         1'b0};
        tbl[7]  = '{1'b0, 1'b1, 32'd512,      32'hA5A5_5A5A, 18'h3FF00,   32'h0,         1'b1};
        tbl[8]  = '{1'b1, 1'b0, 32'd512,      32'h0,         18'h3FF00,   32'hA5A5_5A5A, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 32'h0008_03FC, 32'h0F0F_F0F0, 18'h3FFFE,  32'h0,         1'b0};
        tbl[10] = '{1'b1, 1'b0, 32'h0008_03FC, 32'h0,        18'h3FFFE,   32'h0F0F_F0F0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 32'd1028,     32'h0,         18'd2,       32'hDEAD_BEEF, 1'b0};

        rst        = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = 32'h0;
        wdata      = 32'h0;
        last_rdata = 32'h0;

        // Reset: idle outputs, then ready follows the request during reset.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_rdata", rdata, 32'h0);
        check_quiet("rst");
        #1;
        rd_en = 1'b1;
        #1;
        check("rst_ready_req", 32'(ready), 32'd0);
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
`ifdef SRAM_RANGE_CHECK_EN
            if (tbl[i].oob) continue;
`endif
            run_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].lo, tbl[i].exp_rd);
        end

        // Read held through DONE, then a new write in the following IDLE cycle.
        rd_en   = 1'b1;
        address = 32'd1028;
        exp_q.push_back(32'hDEAD_BEEF);
        last_rdata = 32'hDEAD_BEEF;
        for (int c = 0; c <= 2*W+2; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            check($sformatf("b2b_ready_c%0d", c), 32'(ready), 32'd0);
            if (c > 0) check($sformatf("b2b_oe_n_c%0d", c), 32'(sram_oe_n), 32'd0);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check("b2b_ready_done", 32'(ready), 32'd1);
        check_rdata("b2b_rdata_done");
        @(posedge clk);
        #1;
        rd_en   = 1'b0;
        wr_en   = 1'b1;
        address = 32'd1032;
        wdata   = 32'h0BAD_F00D;
        exp_q.push_back(last_rdata);
        @(negedge clk);
        check("b2b_idle_ready", 32'(ready), 32'd0);
        check_quiet("b2b_idle");
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        @(negedge clk);
        check("b2b_low_addr", 32'(sram_addr), 32'd4);
        check("b2b_low_we_n", 32'(sram_we_n), 32'd0);
        check("b2b_low_dq", 32'(sram_dq_out), 32'h0000_F00D);
        repeat (11) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("b2b_ready_c26", 32'(ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("b2b_ready_c27", 32'(ready), 32'd1);
        check_rdata("b2b_wr_rdata");
        @(posedge clk);
        #1;

        // Reset in the middle of the HIGH half of a write.
        wr_en   = 1'b1;
        address = 32'd1044;
        wdata   = 32'h1111_2222;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        check("mid_c8_addr", 32'(sram_addr), 32'd11);
        check("mid_c8_we_n", 32'(sram_we_n), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_c9_ready", 32'(ready), 32'd1);
        check("mid_c9_rdata", rdata, 32'h0);
        check_quiet("mid_c9");
        last_rdata = 32'h0;
        @(posedge clk);
        #1;
        run_txn(1'b1, 1'b0, 32'd1028, 32'h0, 18'd2, 32'hDEAD_BEEF);

`ifdef SRAM_RANGE_CHECK_EN
        // Below the data window: straight to DONE with err and no SRAM activity.
        rd_en   = 1'b1;
        address = 32'd512;
        @(negedge clk);
        check("oob_ready_req", 32'(ready), 32'd0);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        @(negedge clk);
        check("oob_ready_done", 32'(ready), 32'd1);
        check("oob_err", 32'(err), 32'd1);
        check("oob_rdata", rdata, 32'h0);
        check_quiet("oob");
        @(posedge clk);
        #1;
        @(negedge clk);
        check("oob_err_clear", 32'(err), 32'd0);
        check("oob_idle_ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Responder end of the MEM-stage memory interface. It accepts single 32-bit read/write requests from the pipeline's memory stage and performs them on an external asynchronous 16-bit SRAM as two half-word accesses with programmable wait states.
- It drives `ready` low while busy. The pipeline uses `~ready` as its global freeze for the IF/ID/EXE/MEM registers.
- It sits between the EXE2MEM register outputs and the MEM2WB register, replacing the single-cycle data memory.

Parameters:
- WAIT_CYCLES, 5, extra cycles each half-word access is held on the SRAM bus (each half occupies WAIT_CYCLES+1 cycles)
- DATA_BASE, 1024, byte address that maps to SRAM half-word 0
- SRAM_AW, 18, SRAM half-word address width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- rd_en  in  1  read request from MEM stage (MEM_R_EN)
- wr_en  in  1  write request from MEM stage (MEM_W_EN)
- address  in  32  byte address (ALU result)
- wdata  in  32  store data (Val_Rm)
- rdata  out  32  load data to MEM2WB
- ready  out  1  request complete / controller idle; pipeline freeze = ~ready
- sram_addr  out  SRAM_AW  half-word address
- sram_dq_out  out  16  write data to SRAM
- sram_dq_in  in  16  read data from SRAM
- sram_dq_oe  out  1  1 = controller drives DQ
- sram_we_n  out  1  active-low write strobe
- sram_oe_n  out  1  active-low output enable

Behaviour:
- States: IDLE, LOW, HIGH, DONE. Wait counter `cnt` is 0..WAIT_CYCLES.
- Address math:
  - offset = address - DATA_BASE (32-bit, unsigned).
  - word = offset >> 2.
  - LOW half address = {word[SRAM_AW-2:0], 1'b0}; HIGH half address = {word[SRAM_AW-2:0], 1'b1}.
  - Bits 1:0 of the address are ignored.
- IDLE:
  - If rd_en|wr_en, latch address, wdata and op (write wins if both are set), clear cnt, go to LOW.
  - ready = ~(rd_en|wr_en) combinationally, so a new request freezes the pipeline in the same cycle.
- LOW / HIGH:
  - sram_addr holds the half address.
  - Write: sram_dq_oe=1, sram_we_n=0, sram_oe_n=1. sram_dq_out = wdata[15:0] in LOW, wdata[31:16] in HIGH.
  - Read: sram_dq_oe=0, sram_we_n=1, sram_oe_n=0.
  - cnt increments each cycle. When cnt==WAIT_CYCLES: a read samples sram_dq_in into rdata[15:0] (LOW) or rdata[31:16] (HIGH), cnt clears, and the state advances LOW→HIGH or HIGH→DONE.
- DONE: held exactly 1 cycle. ready=1, rdata valid (unchanged after a write), then IDLE unconditionally. A still-asserted request in the following IDLE cycle is treated as a new request, because the pipeline has advanced.
- Latency, counting the request cycle as 0: LOW covers cycles 1..W+1, HIGH covers W+2..2W+2, DONE is cycle 2W+3 (13 for W=5).
- Outside LOW/HIGH: sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
- Request inputs are not re-sampled after acceptance; changes during LOW/HIGH are ignored.
- Reset (rst=0 at a clock edge), including mid-access: state=IDLE, cnt=0, rdata=0, latched registers=0, all SRAM strobes inactive on the next cycle. A partial write may leave the low half written; this is accepted.
- ready during reset: it follows the IDLE rule, i.e. 1 with no request.
- WAIT_CYCLES=0 is legal: each half takes 1 cycle and DONE is cycle 3.

Optional Feature:
- Macro SRAM_RANGE_CHECK_EN.
- When defined:
  - Adds output port `err` (out, 1).
  - A request with address < DATA_BASE or offset >= 2^(SRAM_AW+1) bytes goes IDLE→DONE directly. No SRAM strobes, rdata=0, err=1 for that DONE cycle only.
  - err=0 otherwise and after reset.
- When undefined: no err port; out-of-range offsets are truncated to SRAM_AW bits and wrap.

Decomposition:
- Shared package `sram_pkg` holds:
  - state enum {IDLE, LOW, HIGH, DONE}
  - the half-select constants
  - the DATA_BASE default
  - the SRAM_AW default
- One natural sub-module, `sram_wait_counter`: a loadable 0..WAIT_CYCLES counter with a terminal-count output, used for both halves.
- Everything else lives in one module.

Test Plan:
- Reset then idle, no request → ready=1, sram_we_n=1, sram_oe_n=1, rdata=0.
- Write address=1028, wdata=0xDEADBEEF, W=5 → ready=0 in cycles 0..12.
  - Cycles 1–6: sram_addr=2, dq_out=0xBEEF, we_n=0.
  - Cycles 7–12: sram_addr=3, dq_out=0xDEAD.
  - Cycle 13: ready=1.
- Read address=1028 with SRAM model holding 0xBEEF@2 and 0xDEAD@3 → rdata=0xDEADBEEF and ready=1 in cycle 13, oe_n=0 in cycles 1..12.
- Back-to-back: read held through DONE then a new write address=1032 → IDLE cycle 14 shows ready=0, LOW starts cycle 15 at sram_addr=4.
- Reset mid-write (rst=0 in cycle 8) → cycle 9: state IDLE, we_n=1, dq_oe=0, rdata=0; a subsequent read completes normally.
- SRAM_RANGE_CHECK_EN defined, read address=512 → DONE in cycle 1, err=1, rdata=0, no strobes. Without the macro, the same address wraps and performs a normal 13-cycle access.
